// File: rtl/conv1_spike_fifo.sv
// Elastic buffer from conv layer 1 spike emits to the next layer's AER input.
// Filters zero and repeated words, spaces events with a zero gap, and counts losses.
module conv1_spike_fifo #(
    parameter int DEPTH_W     = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic               work_clk,
    input  logic               rst_n,
    input  logic [17:0]        spike_i,
    input  logic               spike_emit_i,
    input  logic               next_req_i,
    output logic [17:0]        aer_o,
    output logic [DEPTH_W:0]   fifo_count,
    output logic               empty,
    output logic               full,
    output logic [7:0]         drop_cnt,
    output logic [7:0]         dup_cnt,
    output logic [7:0]         stall_cnt,
    output logic [1:0]         rd_state
);

    // Handshake: the consumer holds next_req_i=1 while idle. A nonzero change on
    // aer_o is a new event; the consumer takes it by dropping next_req_i to 0 and
    // finishes by raising it again. aer_o returns to 0 before the next event.

    localparam int DEPTH = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] FULL_COUNT = (DEPTH_W + 1)'(DEPTH);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] BUSY    = 2'd2;
    localparam logic [1:0] GAP     = 2'd3;

    logic [17:0]        mem [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic [17:0]        head;
    logic [17:0]        last_sent;
    logic [1:0]         state;
    logic [TW-1:0]      timer;
    logic               push;
    logic               pop;
    logic               drop;
    logic [DEPTH_W:0]   count_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign head     = mem[rd_ptr];
    // full is the registered pre-edge value, so a push while full is refused even
    // when the reader pops in the same cycle.
    assign push     = spike_emit_i && (spike_i != '0) && !full;
    assign drop     = spike_emit_i && ((spike_i == '0) || full);
    assign pop      = (state == IDLE) && !empty && next_req_i;
    assign rd_state = state;

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge work_clk) begin
        if (push) begin
            mem[wr_ptr] <= spike_i;
        end
    end

    always_ff @(posedge work_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            fifo_count <= count_nxt;
            empty      <= (count_nxt == '0);
            full       <= (count_nxt == FULL_COUNT);
        end
    end

    always_ff @(posedge work_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            aer_o     <= '0;
            last_sent <= '0;
            timer     <= '0;
            dup_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    aer_o <= '0;
                    if (pop) begin
                        if (head == last_sent) begin
                            dup_cnt <= sat_inc(dup_cnt);
                        end else begin
                            aer_o     <= head;
                            last_sent <= head;
                            timer     <= '0;
                            state     <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (!next_req_i) begin
                        state <= BUSY;
                    end else if (timer == TIMER_LAST) begin
                        // Consumer never took the event; abandon it.
                        stall_cnt <= sat_inc(stall_cnt);
                        aer_o     <= '0;
                        state     <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BUSY: begin
                    if (next_req_i) begin
                        aer_o <= '0;
                        state <= GAP;
                    end
                end
                default: begin
                    aer_o <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv1_spike_fifo.sv
// Directed bench for conv1_spike_fifo: vector table for a single event, then
// hand-written sequences for overflow, filtering, timeout, push/pop and reset.
module tb_conv1_spike_fifo;

    logic        work_clk;
    logic        rst_n;
    logic [17:0] spike_i;
    logic        spike_emit_i;
    logic        next_req_i;
    logic [17:0] aer_o;
    logic [4:0]  fifo_count;
    logic        empty;
    logic        full;
    logic [7:0]  drop_cnt;
    logic [7:0]  dup_cnt;
    logic [7:0]  stall_cnt;
    logic [1:0]  rd_state;

    int total = 0;
    int bad   = 0;
    logic [17:0] exp_q[$];

    localparam logic [1:0] ST_BUSY = 2'd2;

    typedef struct {
        logic        emit;
        logic [17:0] spike;
        logic        req;
        logic [17:0] exp_aer;
        logic [4:0]  exp_cnt;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    vec_t tbl[11];

    conv1_spike_fifo #(.DEPTH_W(4), .ACK_TIMEOUT(8)) dut (
        .work_clk     (work_clk),
        .rst_n        (rst_n),
        .spike_i      (spike_i),
        .spike_emit_i (spike_emit_i),
        .next_req_i   (next_req_i),
        .aer_o        (aer_o),
        .fifo_count   (fifo_count),
        .empty        (empty),
        .full         (full),
        .drop_cnt     (drop_cnt),
        .dup_cnt      (dup_cnt),
        .stall_cnt    (stall_cnt),
        .rd_state     (rd_state)
    );

    // Clock and reset
    initial work_clk = 1'b0;
    always #5 work_clk = ~work_clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge work_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic req);
        rst_n        = 1'b0;
        spike_emit_i = 1'b0;
        spike_i      = '0;
        next_req_i   = req;
        repeat (2) @(posedge work_clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Driver tasks
    task automatic emit_word(input logic [17:0] v);
        spike_emit_i = 1'b1;
        spike_i      = v;
        tick();
        spike_emit_i = 1'b0;
        spike_i      = '0;
    endtask

    // Waits for an event, compares it, then runs one accept handshake.
    task automatic consume(input logic [17:0] expv);
        int n;
        n = 0;
        while (aer_o == '0 && n < 50) begin
            tick();
            n++;
        end
        chk("consume_word", 32'(aer_o), 32'(expv));
        next_req_i = 1'b0;
        tick();
        chk("busy_hold", 32'(aer_o), 32'(expv));
        next_req_i = 1'b1;
        tick();
        chk("gap_zero", 32'(aer_o), 32'h0);
    endtask

    function automatic logic [17:0] timeout_exp(input int k);
        logic [17:0] vals [3];
        vals[0] = 18'h00011;
        vals[1] = 18'h00022;
        vals[2] = 18'h00033;
        for (int e = 0; e < 3; e++) begin
            if (k >= 1 + 10 * e && k <= 8 + 10 * e) return vals[e];
        end
        return '0;
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 18'h00123, 1'b1, 18'h00000, 5'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 18'h00000, 1'b1, 18'h00123, 5'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 18'h00000, 1'b1, 18'h00123, 5'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 18'h00000, 1'b0, 18'h00123, 5'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 18'h00000, 1'b0, 18'h00123, 5'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 18'h00000, 1'b0, 18'h00123, 5'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 18'h00000, 1'b0, 18'h00123, 5'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 18'h00000, 1'b0, 18'h00123, 5'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 18'h00000, 1'b1, 18'h00000, 5'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 18'h00000, 1'b1, 18'h00000, 5'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 18'h00000, 1'b1, 18'h00000, 5'd0, 1'b1, 1'b0};

        // Reset state
        do_reset(1'b1);
        chk("rst_aer", 32'(aer_o), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_dup", 32'(dup_cnt), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);

        // Single event, table driven
        for (int i = 0; i < 11; i++) begin
            spike_emit_i = tbl[i].emit;
            spike_i      = tbl[i].spike;
            next_req_i   = tbl[i].req;
            tick();
            chk($sformatf("vec%0d_aer", i), 32'(aer_o), 32'(tbl[i].exp_aer));
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].exp_empty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].exp_full));
        end
        chk("single_drop", 32'(drop_cnt), 32'h0);
        chk("single_dup", 32'(dup_cnt), 32'h0);
        chk("single_stall", 32'(stall_cnt), 32'h0);

        // Overflow then ordered drain
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            emit_word(18'h00100 + 18'(i));
            if (i < 16) exp_q.push_back(18'h00100 + 18'(i));
        end
        chk("ovf_count", 32'(fifo_count), 32'd16);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_drop", 32'(drop_cnt), 32'd4);
        chk("ovf_aer_idle", 32'(aer_o), 32'h0);
        next_req_i = 1'b1;
        while (exp_q.size() > 0) begin
            consume(exp_q.pop_front());
        end
        repeat (5) tick();
        chk("ovf_drained_count", 32'(fifo_count), 32'h0);
        chk("ovf_drained_aer", 32'(aer_o), 32'h0);

        // Duplicate and zero filtering
        do_reset(1'b0);
        emit_word(18'h00005);
        emit_word(18'h00005);
        emit_word(18'h00000);
        emit_word(18'h00007);
        chk("dupz_count", 32'(fifo_count), 32'd3);
        next_req_i = 1'b1;
        consume(18'h00005);
        consume(18'h00007);
        repeat (5) tick();
        chk("dupz_aer_quiet", 32'(aer_o), 32'h0);
        chk("dupz_dup", 32'(dup_cnt), 32'd1);
        chk("dupz_drop", 32'(drop_cnt), 32'd1);
        chk("dupz_count_end", 32'(fifo_count), 32'h0);

        // Timeout with request stuck high
        do_reset(1'b1);
        for (int k = 0; k < 32; k++) begin
            spike_emit_i = (k < 3);
            spike_i      = (k == 0) ? 18'h00011 : (k == 1) ? 18'h00022 : (k == 2) ? 18'h00033 : 18'h0;
            tick();
            chk($sformatf("tmo_aer_%0d", k), 32'(aer_o), 32'(timeout_exp(k)));
        end
        chk("tmo_stall", 32'(stall_cnt), 32'd3);
        chk("tmo_count", 32'(fifo_count), 32'h0);

        // Push refused while full even with a same-cycle pop
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) emit_word(18'h00200 + 18'(i));
        spike_emit_i = 1'b1;
        spike_i      = 18'h003FF;
        next_req_i   = 1'b1;
        tick();
        spike_emit_i = 1'b0;
        next_req_i   = 1'b0;
        chk("pp_full_count", 32'(fifo_count), 32'd15);
        chk("pp_full_drop", 32'(drop_cnt), 32'd1);
        chk("pp_full_flag", 32'(full), 32'h0);
        chk("pp_full_aer", 32'(aer_o), 32'h00200);

        // Push and pop together on a partly filled FIFO
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) emit_word(18'h00300 + 18'(i));
        spike_emit_i = 1'b1;
        spike_i      = 18'h00333;
        next_req_i   = 1'b1;
        tick();
        spike_emit_i = 1'b0;
        next_req_i   = 1'b0;
        chk("pp_mid_count", 32'(fifo_count), 32'd3);
        chk("pp_mid_drop", 32'(drop_cnt), 32'h0);
        chk("pp_mid_aer", 32'(aer_o), 32'h00300);

        // Asynchronous reset while BUSY with a word still buffered
        do_reset(1'b1);
        emit_word(18'h00ABC);
        emit_word(18'h00DEF);
        next_req_i = 1'b0;
        tick();
        chk("rb_state_busy", 32'(rd_state), 32'(ST_BUSY));
        chk("rb_count_pre", 32'(fifo_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rb_aer", 32'(aer_o), 32'h0);
        chk("rb_count", 32'(fifo_count), 32'h0);
        chk("rb_empty", 32'(empty), 32'h1);
        #1;
        rst_n      = 1'b1;
        next_req_i = 1'b1;
        emit_word(18'h00456);
        tick();
        chk("rb_new_event", 32'(aer_o), 32'h00456);
        next_req_i = 1'b0;
        tick();
        next_req_i = 1'b1;
        repeat (6) begin
            tick();
            chk("rb_no_replay", 32'(aer_o), 32'h0);
        end

        // Drop counter saturation
        do_reset(1'b0);
        spike_emit_i = 1'b1;
        spike_i      = '0;
        repeat (260) tick();
        spike_emit_i = 1'b0;
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        chk("sat_count", 32'(fifo_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
